alu_seq: RTL and testbench

Parametrised, registered successor to the team's 8-bit combinational ALU. It keeps the five existing operations (add, subtract, AND, OR, invert), adds XOR, a barrel left shift and an iterative multi-cycle unsigned multiply, and returns zero/carry/overflow flags. Operands enter and results leave through valid/ready handshakes, so the block sits between an operand-issue stage and a result-writeback stage in datapath designs.

---
 rtl/alu_seq.sv | 139 +++++++++++++
 tb/tb_alu_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops 0-6, iterative shift-add unsigned multiply for op 7.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_out;
    logic                 r_zero, r_carry, r_ovf, r_out_valid;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [SHW-1:0]       r_cnt;

    logic [WIDTH:0]       w_sum, w_dif, w_shl;
    logic [SHW-1:0]       w_sh;
    logic [WIDTH-1:0]     w_res;
    logic                 w_c, w_v, w_accept;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    assign in_ready  = (r_state == S_IDLE) || (r_state == S_HOLD && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out       = r_out;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

    // Extra top bit captures carry-out, borrow and the last bit shifted out.
    assign w_sh  = b[SHW-1:0];
    assign w_sum = {1'b0, a} + {1'b0, b};
    assign w_dif = {1'b0, a} - {1'b0, b};
    assign w_shl = {1'b0, a} << w_sh;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (opcode)
            3'd0: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                w_res = w_dif[WIDTH-1:0];
                w_c   = w_dif[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2: w_res = a & b;
            3'd3: w_res = a | b;
            3'd4: w_res = ~a;
            3'd5: w_res = a ^ b;
            3'd6: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        if (opcode == 3'd7) begin
                            r_mcand     <= {{WIDTH{1'b0}}, a};
                            r_mplier    <= b;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_state     <= S_BUSY;
                        end else begin
                            r_out       <= w_res;
                            r_zero      <= (w_res == '0);
                            r_carry     <= w_c;
                            r_ovf       <= w_v;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end else if (r_state == S_HOLD && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // Last step: publish straight from the next-accumulator value.
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_out       <= w_acc_nxt[WIDTH-1:0];
                        r_zero      <= (w_acc_nxt[WIDTH-1:0] == '0);
                        r_carry     <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: scoreboard queue filled on issue,
// drained by a monitor on each output handshake.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   opcode = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;
    logic         zero, carry, ovf;

    typedef struct packed {
        logic [W-1:0] o;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .carry(carry), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int ux, uy, sx, sy, r, sh;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y);
        e = '0;
        r = 0;
        case (op)
            3'd0: begin r = ux + uy; e.o = r[W-1:0]; e.c = (r > 255); e.v = (sx + sy > 127) || (sx + sy < -128); end
            3'd1: begin r = ux - uy; e.o = r[W-1:0]; e.c = (ux < uy); e.v = (sx - sy > 127) || (sx - sy < -128); end
            3'd2: e.o = x & y;
            3'd3: e.o = x | y;
            3'd4: e.o = ~x;
            3'd5: e.o = x ^ y;
            3'd6: begin sh = uy % W; r = ux << sh; e.o = r[W-1:0]; e.c = (sh > 0) ? r[W] : 1'b0; end
            default: begin r = ux * uy; e.o = r[W-1:0]; e.c = ((r >> W) != 0); end
        endcase
        e.z = (e.o == 0);
        return e;
    endfunction

    // Monitor: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got out=%h z=%b c=%b v=%b with nothing expected", out, zero, carry, ovf);
            end else begin
                mon_e = q.pop_front();
                if ({out, zero, carry, ovf} !== mon_e) begin
                    errors++;
                    $display("FAIL result: got out=%h z=%b c=%b v=%b, expected out=%h z=%b c=%b v=%b",
                             out, zero, carry, ovf, mon_e.o, mon_e.z, mon_e.c, mon_e.v);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        bit ok = 1'b0;
        in_valid = 1'b1; opcode = op; a = x; b = y;
        q.push_back(model(op, x, y));
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; opcode = 3'($urandom); a = W'($urandom); b = W'($urandom);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: op=%0d in_ready never 1, expected accept within 50 cycles", op);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
        checks++; if ({zero, carry, ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {zero, carry, ovf}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        out_ready = 1'b1;
        issue(3'd0, 8'd200, 8'd100);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: out_valid=%b expected 1", out_valid); end
        issue(3'd0, 8'd100, 8'd50);
        issue(3'd1, 8'd5, 8'd5);
        issue(3'd1, 8'd3, 8'd5);
        issue(3'd1, 8'h80, 8'h01);
        drain();
    endtask

    task automatic test_logic_shift();
        out_ready = 1'b1;
        issue(3'd6, 8'h81, 8'hF9);
        issue(3'd6, 8'hA5, 8'h00);
        issue(3'd6, 8'h01, 8'h07);
        issue(3'd5, 8'hF0, 8'hFF);
        issue(3'd4, 8'h00, 8'h00);
        issue(3'd2, 8'hCC, 8'hAA);
        issue(3'd3, 8'hCC, 8'hAA);
        drain();
    endtask

    task automatic test_multiply(input logic [W-1:0] x, input logic [W-1:0] y);
        out_ready = 1'b1;
        issue(3'd7, x, y);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk); #1;
            a = W'($urandom); b = W'($urandom); opcode = 3'($urandom);
            checks++;
            if (k < W && {out_valid, in_ready} !== 2'b00) begin
                errors++;
                $display("FAIL mul_busy: step %0d out_valid=%b in_ready=%b expected 0 0", k, out_valid, in_ready);
            end else if (k == W && out_valid !== 1'b1) begin
                errors++;
                $display("FAIL mul_latency: out_valid=%b expected 1 after %0d edges", out_valid, W);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(3'd0, 8'd1, 8'd2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, out, zero, carry, ovf} !== {1'b1, 1'b0, 8'd3, 3'b000}) begin
                errors++;
                $display("FAIL backpressure_hold: valid=%b ready=%b out=%h flags=%b expected 1 0 03 000",
                         out_valid, in_ready, out, {zero, carry, ovf});
            end
        end
        out_ready = 1'b1;
        issue(3'd0, 8'd7, 8'd8);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL backpressure_release: out_valid=%b expected 1", out_valid); end
        drain();
    endtask

    task automatic test_back_to_back();
        int start;
        out_ready = 1'b1;
        start = cyc;
        for (int i = 0; i < 10; i++) begin
            issue(3'd0, W'(i * 23 + 5), W'(i * 41 + 200));
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: result %0d out_valid=%b expected 1", i, out_valid); end
        end
        checks++;
        if (cyc - start != 10) begin errors++; $display("FAIL b2b_rate: took %0d cycles expected 10", cyc - start); end
        drain();
    endtask

    task automatic test_reset_busy();
        bit seen = 1'b0;
        out_ready = 1'b1;
        issue(3'd7, 8'd15, 8'd17);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if ({out_valid, out, zero, carry, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_abort: valid=%b out=%h flags=%b expected all 0", out_valid, out, {zero, carry, ovf});
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_abort_ready: got %b expected 1", in_ready); end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL stale_result: out_valid=1 after aborted multiply, expected 0"); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic_shift();
        test_multiply(8'd15, 8'd17);
        test_multiply(8'd16, 8'd16);
        test_multiply(8'd255, 8'd255);
        test_backpressure();
        test_back_to_back();
        test_reset_busy();
        // Multiply still works after an aborted one.
        test_multiply(8'd13, 8'd11);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
